// File: rtl/proc_sequencer_pkg.sv
// Shared definitions for the program sequencer: sequencer state encoding,
// instruction word width and the halt opcode that ends a program.
package proc_sequencer_pkg;

  localparam int unsigned WORD_W  = 16;
  localparam logic [2:0]  HALT_OP = 3'b111;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_HALT,
    S_ERR
  } state_t;

  // A word whose top three bits equal HALT_OP stops the program instead of
  // being handed to the processor.
  function automatic logic is_halt(input logic [WORD_W-1:0] w);
    return w[WORD_W-1 -: 3] == HALT_OP;
  endfunction

endpackage

// File: rtl/proc_sequencer_if.sv
// Bundle of the sequencer's control, load and processor-handshake signals.
//   master : sequencer side (drives DIN/Run and status, receives requests)
//   slave  : test/load logic plus processor side (drives Go/Stop/Load*/Done)
// Signals:
//   Go, Stop            start / stop-at-boundary requests
//   LoadEn/Addr/Data    program memory write port (honoured when not busy)
//   Done                processor completion pulse
//   DIN, Run            instruction word and one-cycle issue strobe
//   PC, Count           current address, completed instruction count
//   Busy, Halted, Error status decoded from the sequencer state
interface proc_sequencer_if #(
  parameter int unsigned AW = 5
);
  logic                                Go;
  logic                                Stop;
  logic                                LoadEn;
  logic [AW-1:0]                       LoadAddr;
  logic [proc_sequencer_pkg::WORD_W-1:0] LoadData;
  logic                                Done;
  logic [proc_sequencer_pkg::WORD_W-1:0] DIN;
  logic                                Run;
  logic [AW-1:0]                       PC;
  logic                                Busy;
  logic                                Halted;
  logic                                Error;
  logic [15:0]                         Count;

  modport master (
    input  Go, Stop, LoadEn, LoadAddr, LoadData, Done,
    output DIN, Run, PC, Busy, Halted, Error, Count
  );

  modport slave (
    output Go, Stop, LoadEn, LoadAddr, LoadData, Done,
    input  DIN, Run, PC, Busy, Halted, Error, Count
  );
endinterface

// File: rtl/proc_sequencer_prog_mem.sv
// Program memory: 2^AW words, one synchronous write port and an
// asynchronous read port. Contents are not reset.
//   clk   : write clock
//   we    : write enable
//   waddr : write address, wdata : write data
//   raddr : read address,  rdata : read data (combinational)
module prog_mem
  import proc_sequencer_pkg::*;
#(
  parameter int unsigned AW = 5
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [WORD_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/proc_sequencer.sv
// Program sequencer: steps through program memory, issuing one word at a
// time to the processor with a one-cycle Run strobe and waiting for Done.
// Stops on a halt word, after the last memory word, on a Stop request at
// the next instruction boundary, or with Error when Done never arrives.
//   Clock : rising-edge clock
//   Reset : asynchronous, active-high
//   bus   : master side of proc_sequencer_if (requests, load port,
//           Done in; DIN, Run, PC, Count and status out)
module proc_sequencer
  import proc_sequencer_pkg::*;
#(
  parameter int unsigned AW      = 5,
  parameter int unsigned TIMEOUT = 7
) (
  input  logic               Clock,
  input  logic               Reset,
  proc_sequencer_if.master   bus
);

  localparam int unsigned   WCW     = $clog2(TIMEOUT + 1);
  localparam logic [AW-1:0] PC_LAST = '1;

  state_t            state;
  logic [AW-1:0]     pc;
  logic [15:0]       count;
  logic [WCW-1:0]    wait_cnt;
  logic              stop_flag;
  logic [WORD_W-1:0] word;
  logic              halt_word;
  logic              can_cmd;
  logic              mem_we;

  // Go and LoadEn are only honoured while nothing is in flight.
  assign can_cmd   = (state == S_IDLE) || (state == S_HALT) || (state == S_ERR);
  assign mem_we    = bus.LoadEn && can_cmd;
  assign halt_word = is_halt(word);

  prog_mem #(.AW(AW)) u_mem (
    .clk   (Clock),
    .we    (mem_we),
    .waddr (bus.LoadAddr),
    .wdata (bus.LoadData),
    .raddr (pc),
    .rdata (word)
  );

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state     <= S_IDLE;
      pc        <= '0;
      count     <= '0;
      wait_cnt  <= '0;
      stop_flag <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_HALT, S_ERR: begin
          if (bus.Go) begin
            pc        <= '0;
            count     <= '0;
            stop_flag <= 1'b0;
            state     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (bus.Stop) stop_flag <= 1'b1;
          if (halt_word) begin
            state <= S_HALT;
          end else begin
            wait_cnt <= '0;
            state    <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (bus.Stop) stop_flag <= 1'b1;
          // Done is checked before the timeout so a completion on the last
          // allowed WAIT cycle still counts.
          if (bus.Done) begin
            if (count != '1) count <= count + 16'd1;
            if (stop_flag) begin
              pc    <= pc + AW'(1);
              state <= S_IDLE;
            end else if (pc == PC_LAST) begin
              state <= S_HALT;
            end else begin
              pc    <= pc + AW'(1);
              state <= S_ISSUE;
            end
          end else if (wait_cnt == WCW'(TIMEOUT - 1)) begin
            state <= S_ERR;
          end else begin
            wait_cnt <= wait_cnt + WCW'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Outputs decode from state and the addressed memory word only, so Done
  // never reaches Run combinationally.
  assign bus.Run    = (state == S_ISSUE) && !halt_word;
  assign bus.DIN    = (state == S_ISSUE) ? word : '0;
  assign bus.Busy   = (state == S_ISSUE) || (state == S_WAIT);
  assign bus.Halted = (state == S_HALT);
  assign bus.Error  = (state == S_ERR);
  assign bus.PC     = pc;
  assign bus.Count  = count;

endmodule

// File: tb/tb_proc_sequencer.sv
module tb_proc_sequencer;
  import proc_sequencer_pkg::*;

  localparam int AW      = 5;
  localparam int TIMEOUT = 7;

  logic Clock = 1'b0;
  logic Reset;

  always #5 Clock = ~Clock;

  proc_sequencer_if #(.AW(AW)) bus ();
  proc_sequencer_if #(.AW(2))  bus2 ();

  proc_sequencer #(.AW(AW), .TIMEOUT(TIMEOUT)) u_dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus)
  );

  proc_sequencer #(.AW(2), .TIMEOUT(TIMEOUT)) u_dut2 (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus2)
  );

  int errors = 0;
  int checks = 0;

  logic [15:0] model_mem [32];

  typedef struct {
    logic [15:0] w0, w1, w2, w3;
    int          n;
    int          stop_cyc;
    int          lat_ovr;
    int          exp_count;
    int          exp_pc;
    logic        exp_halted;
    logic        exp_error;
  } case_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic idle_inputs();
    bus.Go = 1'b0; bus.Stop = 1'b0; bus.LoadEn = 1'b0;
    bus.LoadAddr = '0; bus.LoadData = '0; bus.Done = 1'b0;
    bus2.Go = 1'b0; bus2.Stop = 1'b0; bus2.LoadEn = 1'b0;
    bus2.LoadAddr = '0; bus2.LoadData = '0; bus2.Done = 1'b0;
  endtask

  task automatic load(input int a, input logic [15:0] d);
    bus.LoadEn = 1'b1; bus.LoadAddr = 5'(a); bus.LoadData = d;
    tick();
    bus.LoadEn = 1'b0;
    model_mem[a] = d;
  endtask

  // Processor latency after the Run cycle: ALU ops take three more cycles,
  // everything else one. A positive override replaces it (timeout tests).
  function automatic int lat_of(input logic [15:0] w, input int ovr);
    if (ovr > 0) return ovr;
    return (w[15:13] == 3'b010 || w[15:13] == 3'b011) ? 3 : 1;
  endfunction

  // Start a program with Go, play the processor, and compare against a
  // transaction-level walk of model_mem. Go is sampled at edge 0, so the
  // first ISSUE is cycle 1.
  task automatic run_prog(input string name, input int stop_cyc, input int lat_ovr,
                          input int poke_cyc, input bit go_load, input logic [15:0] go_word,
                          output int o_count, output int o_pc,
                          output logic o_halted, output logic o_error);
    int          exp_t[$];
    logic [15:0] exp_w[$];
    logic [15:0] w;
    int pc, t, d, L, cnt, end_cyc, exp_end, halt_issue, done_at, t0;
    bit extra_run, busy_bad, din_bad;
    if (go_load) model_mem[0] = go_word;
    pc = 0; t = 1; cnt = 0; halt_issue = -1; exp_end = 0; end_cyc = 0;
    while (1) begin
      w = model_mem[pc];
      if (w[15:13] == 3'b111) begin
        exp_end = 1; end_cyc = t + 1; halt_issue = t; break;
      end
      exp_t.push_back(t); exp_w.push_back(w);
      L = lat_of(w, lat_ovr);
      if (L > TIMEOUT) begin
        exp_end = 2; end_cyc = t + TIMEOUT + 1; break;
      end
      d = t + L; cnt++;
      if (stop_cyc >= 1 && stop_cyc < d) begin
        exp_end = 0; end_cyc = d + 1; pc = (pc + 1) % 32; break;
      end
      if (pc == 31) begin
        exp_end = 1; end_cyc = d + 1; break;
      end
      pc++; t = d + 1;
    end

    bus.Go = 1'b1;
    if (go_load) begin
      bus.LoadEn = 1'b1; bus.LoadAddr = '0; bus.LoadData = go_word;
    end
    tick();
    bus.Go = 1'b0; bus.LoadEn = 1'b0;
    done_at = -1; extra_run = 0; busy_bad = 0; din_bad = 0;
    for (int c = 1; c <= end_cyc; c++) begin
      bus.Done = (c == done_at);
      bus.Stop = (c == stop_cyc);
      if (c == poke_cyc) begin
        bus.Go = 1'b1; bus.LoadEn = 1'b1; bus.LoadAddr = '0; bus.LoadData = 16'hE000;
      end else begin
        bus.Go = 1'b0; bus.LoadEn = 1'b0;
      end
      @(negedge Clock);
      if (bus.Run === 1'b1) begin
        if (exp_t.size() == 0) extra_run = 1;
        else begin
          t0 = exp_t.pop_front();
          w  = exp_w.pop_front();
          check({name, " run_cycle"}, 32'(c), 32'(t0));
          check({name, " din"}, 32'(bus.DIN), 32'(w));
        end
        done_at = c + lat_of(bus.DIN, lat_ovr);
      end else if (bus.DIN !== 16'h0000 && c != halt_issue) begin
        din_bad = 1;
      end
      if (c < end_cyc && bus.Busy !== 1'b1) busy_bad = 1;
      if (c < end_cyc) tick();
    end
    check({name, " end_busy"},   32'(bus.Busy),   32'(0));
    check({name, " end_halted"}, 32'(bus.Halted), 32'(exp_end == 1));
    check({name, " end_error"},  32'(bus.Error),  32'(exp_end == 2));
    check({name, " end_pc"},     32'(bus.PC),     32'(pc));
    check({name, " end_count"},  32'(bus.Count),  32'(cnt));
    check({name, " missing_runs"}, 32'(exp_t.size()), 32'(0));
    check({name, " extra_run"},  32'(extra_run), 32'(0));
    check({name, " busy_gap"},   32'(busy_bad),  32'(0));
    check({name, " din_leak"},   32'(din_bad),   32'(0));
    o_count = int'(bus.Count); o_pc = int'(bus.PC);
    o_halted = bus.Halted; o_error = bus.Error;
    bus.Go = 1'b0; bus.LoadEn = 1'b0; bus.Stop = 1'b0; bus.Done = 1'b0;
    @(posedge Clock);
    #1;
    @(negedge Clock);
    check({name, " quiet_after"}, 32'({bus.Run, bus.Busy}), 32'(0));
    tick();
  endtask

  function automatic case_t mk(input logic [15:0] w0, w1, w2, w3, input int n,
                               input int stop_cyc, input int lat_ovr, input int cnt,
                               input int pc, input logic h, input logic e);
    case_t r;
    r.w0 = w0; r.w1 = w1; r.w2 = w2; r.w3 = w3; r.n = n;
    r.stop_cyc = stop_cyc; r.lat_ovr = lat_ovr;
    r.exp_count = cnt; r.exp_pc = pc; r.exp_halted = h; r.exp_error = e;
    return r;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    case_t cases[8];
    logic [15:0] wl[4];
    int   rc, rp, len, sc, runs, halt_cyc, d2;
    logic rh, re;

    cases[0] = mk(16'h1005, 16'h5003, 16'hE000, 16'h0000, 3, -1, 0,    2, 2, 1'b1, 1'b0);
    cases[1] = mk(16'hE000, 16'h0000, 16'h0000, 16'h0000, 1, -1, 0,    0, 0, 1'b1, 1'b0);
    cases[2] = mk(16'h2000, 16'h6001, 16'h1001, 16'hE000, 4, -1, 0,    3, 3, 1'b1, 1'b0);
    cases[3] = mk(16'h1000, 16'hFFFF, 16'h0000, 16'h0000, 2, -1, 0,    1, 1, 1'b1, 1'b0);
    cases[4] = mk(16'h1005, 16'h0000, 16'h0000, 16'h0000, 1, -1, 1000, 0, 0, 1'b0, 1'b1);
    cases[5] = mk(16'h1005, 16'h1006, 16'hE000, 16'h0000, 3, -1, 7,    2, 2, 1'b1, 1'b0);
    cases[6] = mk(16'h5003, 16'h1005, 16'hE000, 16'h0000, 3,  2, 0,    1, 1, 1'b0, 1'b0);
    cases[7] = mk(16'h1001, 16'h1002, 16'h1003, 16'hE000, 4,  3, 0,    2, 2, 1'b0, 1'b0);

    for (int i = 0; i < 32; i++) model_mem[i] = 16'h0000;
    Reset = 1'b1;
    idle_inputs();
    repeat (2) @(posedge Clock);
    #3;
    check("reset_outputs",
          32'({bus.Run, bus.Busy, bus.Halted, bus.Error, bus2.Run, bus2.Busy}), 32'(0));
    check("reset_din",   32'(bus.DIN),   32'(0));
    check("reset_pc",    32'(bus.PC),    32'(0));
    check("reset_count", 32'(bus.Count), 32'(0));
    Reset = 1'b0;
    tick();

    for (int i = 0; i < 8; i++) begin
      wl[0] = cases[i].w0; wl[1] = cases[i].w1; wl[2] = cases[i].w2; wl[3] = cases[i].w3;
      for (int k = 0; k < cases[i].n; k++) load(k, wl[k]);
      run_prog($sformatf("vec%0d", i), cases[i].stop_cyc, cases[i].lat_ovr, -1, 1'b0, 16'h0,
               rc, rp, rh, re);
      check($sformatf("vec%0d count", i),  32'(rc), 32'(cases[i].exp_count));
      check($sformatf("vec%0d pc", i),     32'(rp), 32'(cases[i].exp_pc));
      check($sformatf("vec%0d halted", i), 32'(rh), 32'(cases[i].exp_halted));
      check($sformatf("vec%0d error", i),  32'(re), 32'(cases[i].exp_error));
    end

    // Done while idle must not count.
    bus.Done = 1'b1; tick(); tick(); bus.Done = 1'b0;
    @(negedge Clock);
    check("idle_done_count", 32'(bus.Count), 32'(cases[7].exp_count));
    check("idle_done_busy",  32'(bus.Busy),  32'(0));
    tick();

    // Randomised programs, some with a Stop pulse.
    for (int it = 0; it < 20; it++) begin
      len = int'($urandom_range(1, 8));
      for (int k = 0; k < len; k++) begin
        wl[0] = 16'($urandom);
        if (wl[0][15:13] == 3'b111) wl[0][15] = 1'b0;
        load(k, wl[0]);
      end
      load(len, 16'hE000 | 16'($urandom_range(0, 16'h1FFF)));
      sc = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 4 * len)) : -1;
      run_prog($sformatf("rand%0d", it), sc, 0, -1, 1'b0, 16'h0, rc, rp, rh, re);
    end

    // Go and LoadEn while busy are ignored; a later run still sees mem[0].
    load(0, 16'h1005); load(1, 16'h5003); load(2, 16'hE000);
    run_prog("busy_poke", -1, 0, 2, 1'b0, 16'h0, rc, rp, rh, re);
    run_prog("after_poke", -1, 0, -1, 1'b0, 16'h0, rc, rp, rh, re);

    // LoadEn and Go together: the new word is issued first.
    run_prog("load_and_go", -1, 0, -1, 1'b1, 16'h1077, rc, rp, rh, re);

    // Reset in the middle of a WAIT.
    load(0, 16'h1001); load(1, 16'h5003); load(2, 16'hE000);
    bus.Go = 1'b1; tick(); bus.Go = 1'b0;   // cycle 1: ISSUE mv
    tick();                                 // cycle 2: WAIT
    bus.Done = 1'b1; tick(); bus.Done = 1'b0; // cycle 3: ISSUE add
    tick();                                 // cycle 4: WAIT
    check("pre_reset_count", 32'(bus.Count), 32'(1));
    check("pre_reset_busy",  32'(bus.Busy),  32'(1));
    #2 Reset = 1'b1;
    #1;
    check("midreset_outputs", 32'({bus.Run, bus.Busy}), 32'(0));
    check("midreset_din",     32'(bus.DIN),   32'(0));
    check("midreset_count",   32'(bus.Count), 32'(0));
    check("midreset_pc",      32'(bus.PC),    32'(0));
    @(negedge Clock);
    Reset = 1'b0;
    tick();
    run_prog("after_reset", -1, 0, -1, 1'b0, 16'h0, rc, rp, rh, re);

    // Done while halted must not count.
    bus.Done = 1'b1; tick(); bus.Done = 1'b0;
    @(negedge Clock);
    check("halt_done_count", 32'(bus.Count), 32'(2));
    check("halt_done_state", 32'(bus.Halted), 32'(1));
    tick();

    // AW=2: four mv words, no halt word, runs off the end of memory.
    for (int k = 0; k < 4; k++) begin
      bus2.LoadEn = 1'b1; bus2.LoadAddr = 2'(k); bus2.LoadData = 16'h1001 + 16'(k);
      tick();
    end
    bus2.LoadEn = 1'b0;
    bus2.Go = 1'b1; tick(); bus2.Go = 1'b0;
    runs = 0; halt_cyc = -1; d2 = -1;
    for (int c = 1; c <= 20; c++) begin
      bus2.Done = (c == d2);
      @(negedge Clock);
      if (bus2.Run === 1'b1) begin
        runs++;
        check($sformatf("aw2 run%0d cycle", runs), 32'(c), 32'(2 * runs - 1));
        check($sformatf("aw2 run%0d din", runs), 32'(bus2.DIN), 32'(16'h1000 + 16'(runs)));
        d2 = c + 1;
      end
      if (bus2.Halted === 1'b1) begin
        halt_cyc = c;
        break;
      end
      tick();
    end
    check("aw2 halt_cycle", 32'(halt_cyc), 32'(9));
    check("aw2 runs",       32'(runs),     32'(4));
    check("aw2 pc",         32'(bus2.PC),  32'(3));
    check("aw2 count",      32'(bus2.Count), 32'(4));
    bus2.Done = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
